psr_arbiter: RTL and testbench

Time-shares the cartridge PSRAM between the Mega Drive ROM read path and the MCU loader/backup port. Console reads get strict priority; MCU reads and writes fill idle bus time through a req/ack handshake. All PSRAM strobes are generated by a fixed-length access state machine clocked by the cartridge FPGA clock. The block sits between the bus-decode logic in top and the PSR_* pins.

---
 rtl/psr_arbiter.sv | 155 +++++++++++++++
 tb/tb_psr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_arbiter.sv
// Shares the cartridge PSRAM between console ROM reads (strict priority) and
// MCU req/ack accesses, driving all PSRAM strobes from fixed-length access states.
module psr_arbiter #(
  parameter int ACC_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_rd,
  input  logic [20:0] md_addr,
  output logic [15:0] md_dout,
  output logic        md_dout_vld,
  input  logic        mcu_req,
  input  logic        mcu_we,
  input  logic [21:0] mcu_addr,
  input  logic [15:0] mcu_din,
  output logic [15:0] mcu_dout,
  output logic        mcu_ack,
  output logic [21:0] psr_a,
  input  logic [15:0] psr_di,
  output logic [15:0] psr_do,
  output logic        psr_doe,
  output logic        psr_ce_n,
  output logic        psr_oe_n,
  output logic        psr_we_n,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MD    = 2'd1;
  localparam logic [1:0] S_MCU   = 2'd2;
  localparam logic [1:0] S_RECOV = 2'd3;
  localparam logic [3:0] LAST    = 4'(ACC_CYC - 1);
  localparam logic [3:0] WE_LAST = 4'(ACC_CYC - 2);

  logic        sync1_q, sync2_q, sync3_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        md_pend_q, md_pend_d;
  logic        md_served_q, md_served_d;
  logic        we_q, we_d;
  logic [21:0] psr_a_q, psr_a_d;
  logic [15:0] psr_do_q, psr_do_d;
  logic        psr_doe_q, psr_doe_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [15:0] md_dout_q, md_dout_d, mcu_dout_q, mcu_dout_d;
  logic        vld_q, vld_d, ack_q, ack_d, busy_q, busy_d;
  logic        md_edge, last, enter_md, enter_mcu, md_cap, mcu_cap;

  always_comb begin
    md_edge = sync2_q & ~sync3_q;
    last    = (cnt_q == LAST);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (md_pend_q || md_edge) begin
          state_d = S_MD;
          cnt_d   = 4'd0;
        end else if (mcu_req) begin
          state_d = S_MCU;
          cnt_d   = 4'd0;
        end
      end
      S_MD, S_MCU: begin
        if (last) state_d = S_RECOV;
        else      cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    enter_md  = (state_q == S_IDLE) && (state_d == S_MD);
    enter_mcu = (state_q == S_IDLE) && (state_d == S_MCU);
    md_cap    = (state_q == S_MD)  && last;
    mcu_cap   = (state_q == S_MCU) && last;

    we_d     = enter_mcu ? mcu_we : we_q;
    psr_a_d  = enter_md ? {1'b0, md_addr} : (enter_mcu ? mcu_addr : psr_a_q);
    psr_do_d = enter_mcu ? mcu_din : psr_do_q;

    // Strobes are decoded from the next state so they come straight off flops.
    ce_n_d    = ~((state_d == S_MD) || (state_d == S_MCU));
    oe_n_d    = ~((state_d == S_MD) || ((state_d == S_MCU) && !we_d));
    we_n_d    = ~((state_d == S_MCU) && we_d && (cnt_d >= 4'd1) && (cnt_d <= WE_LAST));
    psr_doe_d = (state_d == S_MCU) && we_d;
    busy_d    = (state_d != S_IDLE);

    md_dout_d  = md_cap ? psr_di : md_dout_q;
    mcu_dout_d = (mcu_cap && !we_q) ? psr_di : mcu_dout_q;
    ack_d      = mcu_cap;
    // sync1_q low means md_rd_s goes low next cycle; clear vld in step with it.
    vld_d      = !sync1_q ? 1'b0 : (md_cap ? sync2_q : vld_q);

    // A read that is still high and never served re-arms the pending flag.
    md_served_d = sync2_q & (md_served_q | enter_md);
    md_pend_d   = enter_md ? 1'b0
                : (md_pend_q | md_edge | (sync2_q & ~vld_q & ~md_served_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      md_pend_q   <= 1'b0;
      md_served_q <= 1'b0;
      we_q        <= 1'b0;
      psr_a_q     <= 22'd0;
      psr_do_q    <= 16'd0;
      psr_doe_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      md_dout_q   <= 16'd0;
      mcu_dout_q  <= 16'd0;
      vld_q       <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= md_rd;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_pend_q   <= md_pend_d;
      md_served_q <= md_served_d;
      we_q        <= we_d;
      psr_a_q     <= psr_a_d;
      psr_do_q    <= psr_do_d;
      psr_doe_q   <= psr_doe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      md_dout_q   <= md_dout_d;
      mcu_dout_q  <= mcu_dout_d;
      vld_q       <= vld_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign md_dout     = md_dout_q;
  assign md_dout_vld = vld_q;
  assign mcu_dout    = mcu_dout_q;
  assign mcu_ack     = ack_q;
  assign psr_a       = psr_a_q;
  assign psr_do      = psr_do_q;
  assign psr_doe     = psr_doe_q;
  assign psr_ce_n    = ce_n_q;
  assign psr_oe_n    = oe_n_q;
  assign psr_we_n    = we_n_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_psr_arbiter.sv
// Bench for psr_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a bus-timeline reference model.
module tb_psr_arbiter;
  localparam int ACC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        md_rd = 1'b0;
  logic [20:0] md_addr = '0;
  logic [15:0] md_dout;
  logic        md_dout_vld;
  logic        mcu_req = 1'b0;
  logic        mcu_we = 1'b0;
  logic [21:0] mcu_addr = '0;
  logic [15:0] mcu_din = '0;
  logic [15:0] mcu_dout;
  logic        mcu_ack;
  logic [21:0] psr_a;
  logic [15:0] psr_di = '0;
  logic [15:0] psr_do;
  logic        psr_doe, psr_ce_n, psr_oe_n, psr_we_n, busy;

  always #5 clk = ~clk;

  psr_arbiter #(.ACC_CYC(ACC)) dut (
    .clk(clk), .rst(rst),
    .md_rd(md_rd), .md_addr(md_addr), .md_dout(md_dout), .md_dout_vld(md_dout_vld),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
    .mcu_dout(mcu_dout), .mcu_ack(mcu_ack),
    .psr_a(psr_a), .psr_di(psr_di), .psr_do(psr_do), .psr_doe(psr_doe),
    .psr_ce_n(psr_ce_n), .psr_oe_n(psr_oe_n), .psr_we_n(psr_we_n), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the bus is a timeline of accesses, each owning
  // [start, start+ACC-1] plus one recovery cycle.
  int          cyc, free_at, a_start, a_kind;   // a_kind: 0 none, 1 console, 2 mcu
  logic [21:0] a_addr;
  logic [15:0] a_din, md_exp, mcu_exp;
  logic        a_we, cons_wait, vld_exp;
  logic        h1, h2, h3;                       // md_rd seen 1, 2, 3 cycles ago

  task automatic model_reset();
    cyc = 0; free_at = 0; a_start = 0; a_kind = 0;
    a_addr = '0; a_din = '0; a_we = 1'b0;
    md_exp = '0; mcu_exp = '0; vld_exp = 1'b0; cons_wait = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_step();
    int   c = cyc;
    logic cap = 1'b0;
    if (h2 && !h3) cons_wait = 1'b1;
    if (a_kind != 0 && c == a_start + ACC - 1) begin
      if (a_kind == 1) begin md_exp = psr_di; cap = 1'b1; end
      else if (!a_we)  mcu_exp = psr_di;
    end
    vld_exp = h1 ? (cap ? h2 : vld_exp) : 1'b0;
    if (c >= free_at) begin
      if (cons_wait) begin
        a_kind = 1; a_addr = {1'b0, md_addr}; a_we = 1'b0;
        cons_wait = 1'b0; a_start = c + 1; free_at = c + ACC + 2;
      end else if (mcu_req) begin
        a_kind = 2; a_addr = mcu_addr; a_we = mcu_we; a_din = mcu_din;
        a_start = c + 1; free_at = c + ACC + 2;
      end
    end
    h3 = h2; h2 = h1; h1 = md_rd;
    cyc++;
  endtask

  task automatic model_compare();
    int   n = cyc;
    int   k = n - a_start;
    logic on = (a_kind != 0) && (n >= a_start) && (n < a_start + ACC);
    logic rec = (a_kind != 0) && (n == a_start + ACC);
    logic wr = on && (a_kind == 2) && a_we;
    chk("ce_n", psr_ce_n, !on);
    chk("oe_n", psr_oe_n, !(on && (a_kind == 1 || !a_we)));
    chk("we_n", psr_we_n, !(wr && k >= 1 && k <= ACC - 2));
    chk("doe", psr_doe, wr);
    chk("ack", mcu_ack, rec && (a_kind == 2));
    chk("busy", busy, on || rec);
    chk("md_dout_vld", md_dout_vld, vld_exp);
    chk("md_dout", md_dout, md_exp);
    chk("mcu_dout", mcu_dout, mcu_exp);
    if (on) chk("psr_a", psr_a, a_addr);
    if (wr) chk("psr_do", psr_do, a_din);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      model_compare();
    end
  end

  // Directed capture buffers, index k = k-th clock after the current negedge.
  logic        r_ce[0:15], r_oe[0:15], r_we[0:15], r_doe[0:15], r_ack[0:15], r_vld[0:15];
  logic [21:0] r_a[0:15];
  logic [15:0] r_md[0:15], r_mcu[0:15];

  task automatic capture(input int n, input int req_k, input int drop_k);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      r_ce[k] = psr_ce_n; r_oe[k] = psr_oe_n; r_we[k] = psr_we_n; r_doe[k] = psr_doe;
      r_ack[k] = mcu_ack; r_vld[k] = md_dout_vld; r_a[k] = psr_a;
      r_md[k] = md_dout; r_mcu[k] = mcu_dout;
      @(negedge clk);
      if (mcu_ack) mcu_req = 1'b0;
      if (k == req_k) mcu_req = 1'b1;
      if (k == drop_k) md_rd = 1'b0;
    end
  endtask

  function automatic int count_ack(input int n);
    int s = 0;
    for (int k = 1; k <= n; k++) s += int'(r_ack[k]);
    return s;
  endfunction

  int md_len;

  initial begin
    int lows;
    int vlds;
    repeat (3) @(negedge clk);
    chk("rst_ce_n", psr_ce_n, 1'b1);
    chk("rst_oe_n", psr_oe_n, 1'b1);
    chk("rst_we_n", psr_we_n, 1'b1);
    chk("rst_doe", psr_doe, 1'b0);
    chk("rst_psr_a", psr_a, 22'd0);
    chk("rst_psr_do", psr_do, 16'd0);
    chk("rst_busy_vld_ack", {busy, md_dout_vld, mcu_ack}, 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Console read
    psr_di = 16'hBEEF; md_addr = 21'h012345; md_rd = 1'b1;
    capture(8, 0, 0);
    lows = 0;
    for (int k = 1; k <= 8; k++) lows += int'(!r_ce[k]);
    chk("md_ce_low_cycles", lows, 4);
    chk("md_psr_a", r_a[3], 22'h012345);
    chk("md_oe_n", r_oe[3], 1'b0);
    chk("md_vld_early", r_vld[6], 1'b0);
    chk("md_vld_on_time", r_vld[7], 1'b1);
    chk("md_data", r_md[7], 16'hBEEF);
    md_rd = 1'b0;
    capture(3, 0, 0);
    chk("md_vld_hold", r_vld[1], 1'b1);
    chk("md_vld_drop", r_vld[2], 1'b0);

    // MCU write
    mcu_addr = 22'h3FFFFF; mcu_din = 16'hA55A; mcu_we = 1'b1; mcu_req = 1'b1;
    capture(7, 0, 0);
    chk("wr_we_n_pattern", {r_we[1], r_we[2], r_we[3], r_we[4]}, 4'b1001);
    chk("wr_doe_pattern", {r_doe[1], r_doe[2], r_doe[3], r_doe[4], r_doe[5]}, 5'b11110);
    chk("wr_oe_n_high", {r_oe[1], r_oe[2], r_oe[3], r_oe[4]}, 4'b1111);
    chk("wr_psr_a", r_a[1], 22'h3FFFFF);
    chk("wr_ack_at", r_ack[5], 1'b1);
    chk("wr_ack_count", count_ack(7), 1);
    mcu_we = 1'b0;

    // MCU read
    psr_di = 16'h1234; mcu_addr = 22'h000010; mcu_req = 1'b1;
    capture(7, 0, 0);
    chk("rd_oe_n_low", {r_oe[1], r_oe[2], r_oe[3], r_oe[4]}, 4'b0000);
    chk("rd_ack_at", r_ack[5], 1'b1);
    chk("rd_data", r_mcu[5], 16'h1234);

    // Console edge and MCU request in the same idle cycle
    psr_di = 16'h5A5A; md_addr = 21'h1ABCDE; md_rd = 1'b1;
    mcu_addr = 22'h2AAAAA; mcu_we = 1'b0;
    capture(14, 2, 0);
    chk("cont_md_first_ce", r_ce[3], 1'b0);
    chk("cont_md_first_a", r_a[3], 22'h1ABCDE);
    chk("cont_mcu_next_a", r_a[9], 22'h2AAAAA);
    chk("cont_gap_ce", r_ce[8], 1'b1);
    chk("cont_ack_at", r_ack[13], 1'b1);
    chk("cont_ack_count", count_ack(14), 1);
    chk("cont_md_data", r_md[7], 16'h5A5A);
    md_rd = 1'b0;
    repeat (3) @(negedge clk);

    // Console edge on the first cycle of an MCU write
    psr_di = 16'hC3C3; md_addr = 21'h054321; md_rd = 1'b1;
    mcu_addr = 22'h000123; mcu_din = 16'h0F0F; mcu_we = 1'b1;
    capture(13, 1, 0);
    chk("late_mcu_doe", r_doe[2], 1'b1);
    chk("late_mcu_ack", r_ack[6], 1'b1);
    chk("late_recov_ce", r_ce[7], 1'b1);
    chk("late_md_ce", r_ce[8], 1'b0);
    chk("late_md_a", r_a[8], 22'h054321);
    chk("late_md_data", r_md[12], 16'hC3C3);
    chk("late_md_vld", r_vld[12], 1'b1);
    md_rd = 1'b0; mcu_we = 1'b0;
    repeat (3) @(negedge clk);

    // Aborted console read with an MCU read queued behind it
    psr_di = 16'h7E57; md_addr = 21'h000777; md_rd = 1'b1;
    mcu_addr = 22'h111111; mcu_we = 1'b0;
    capture(14, 2, 1);
    vlds = 0;
    for (int k = 1; k <= 14; k++) vlds += int'(r_vld[k]);
    chk("abort_md_ce", r_ce[3], 1'b0);
    chk("abort_md_a", r_a[3], 22'h000777);
    chk("abort_md_data", r_md[7], 16'h7E57);
    chk("abort_vld_never", vlds, 0);
    chk("abort_mcu_ack", r_ack[13], 1'b1);
    chk("abort_mcu_data", r_mcu[13], 16'h7E57);

    // Reset in the middle of an MCU write strobe
    mcu_addr = 22'h2468AC; mcu_din = 16'h1357; mcu_we = 1'b1; mcu_req = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("mid_rst_pre_we_n", psr_we_n, 1'b0);
    rst = 1'b1; mcu_req = 1'b0;
    #1;
    chk("mid_rst_ce_n", psr_ce_n, 1'b1);
    chk("mid_rst_we_n", psr_we_n, 1'b1);
    chk("mid_rst_oe_n", psr_oe_n, 1'b1);
    chk("mid_rst_doe", psr_doe, 1'b0);
    chk("mid_rst_ack", mcu_ack, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0; mcu_we = 1'b0;
    capture(8, 0, 0);
    chk("post_rst_no_ack", count_ack(8), 0);
    chk("post_rst_busy", busy, 1'b0);

    // Random traffic
    md_len = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      psr_di = 16'($urandom);
      if (md_rd) begin
        md_len--;
        if (md_len <= 0) md_rd = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        md_rd = 1'b1; md_addr = 21'($urandom); md_len = int'($urandom_range(1, 14));
      end
      if (mcu_req && mcu_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          mcu_we = 1'($urandom); mcu_addr = 22'($urandom); mcu_din = 16'($urandom);
        end else begin
          mcu_req = 1'b0;
        end
      end else if (!mcu_req && $urandom_range(0, 3) == 0) begin
        mcu_req = 1'b1;
        mcu_we = 1'($urandom); mcu_addr = 22'($urandom); mcu_din = 16'($urandom);
      end
    end
    md_rd = 1'b0; mcu_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
